// File: rtl/network_pkg.sv
// Shared types for the stochastic-network host sequencer: FSM state encoding,
// the inference counter width and a small constant helper for sizing the timer.
package network_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_FLUSH,
        S_RUN,
        S_CAPTURE,
        S_HOLD
    } seq_state_t;

    localparam int INFER_CNT_W = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that stops at zero; load wins over counting.
// Zero flag is combinational from the register, so it is valid in the cycle after a load.
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/network_sequencer.sv
// Drives one inference per accepted input vector: settle, flush pulse, WINDOW-cycle run, capture pulse.
// Accept-to-out_valid is 1+SETTLE+1+WINDOW+CAPTURE_LAT cycles; in_ready only in IDLE, result held until out_ready.
module network_sequencer
    import network_pkg::*;
#(
    parameter int INPUT_SIZE  = 2,
    parameter int OUTPUT_SIZE = 1,
    parameter int WINDOW      = 256,
    parameter int SETTLE      = 4,
    parameter int CAPTURE_LAT = 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [31:0]     in_data     [INPUT_SIZE],
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [31:0]     out_data    [OUTPUT_SIZE],
    output logic signed [31:0]     net_input   [INPUT_SIZE],
    output logic                   net_compute,
    input  logic signed [31:0]     net_output  [OUTPUT_SIZE],
    output logic                   busy,
    output logic [INFER_CNT_W-1:0] inference_count
);

    localparam int TW = $clog2(max3(WINDOW, SETTLE, CAPTURE_LAT) + 1);

    seq_state_t              state_q, state_d;
    logic signed [31:0]      net_input_q [INPUT_SIZE];
    logic signed [31:0]      net_input_d [INPUT_SIZE];
    logic signed [31:0]      out_data_q  [OUTPUT_SIZE];
    logic signed [31:0]      out_data_d  [OUTPUT_SIZE];
    logic                    out_valid_q, out_valid_d;
    logic [INFER_CNT_W-1:0]  inference_count_q, inference_count_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    seq_timer #(
        .W(TW)
    ) u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (tmr_load),
        .load_value(tmr_val),
        .zero      (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            net_input_q       <= '{default: '0};
            out_data_q        <= '{default: '0};
            out_valid_q       <= 1'b0;
            inference_count_q <= '0;
        end else begin
            net_input_q       <= net_input_d;
            out_data_q        <= out_data_d;
            out_valid_q       <= out_valid_d;
            inference_count_q <= inference_count_d;
        end
    end

    // Next state plus the data registers and timer loads that move with each transition.
    always_comb begin
        state_d           = state_q;
        net_input_d       = net_input_q;
        out_data_d        = out_data_q;
        out_valid_d       = out_valid_q;
        inference_count_d = inference_count_q;
        tmr_load          = 1'b0;
        tmr_val           = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    net_input_d = in_data;
                    tmr_load    = 1'b1;
                    tmr_val     = TW'(SETTLE - 1);
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_zero) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(WINDOW - 1);
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(CAPTURE_LAT - 1);
                    state_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (tmr_zero) begin
                    out_data_d        = net_output;
                    out_valid_d       = 1'b1;
                    inference_count_d = inference_count_q + 1'b1;
                    state_d           = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The flush pulse and the capture pulse are WINDOW cycles apart, so they never abut.
    always_comb begin
        in_ready    = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        net_compute = (state_q == S_FLUSH) || ((state_q == S_RUN) && tmr_zero);
    end

    assign net_input       = net_input_q;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign inference_count = inference_count_q;

endmodule
